issue_hazard_gate: RTL and testbench

Per-warp register hazard controller between the instruction buffer and operand collection in the issue stage. It tracks outstanding destination-register writes per (warp, register) and holds an instruction while any source or destination register it names still has a write pending. Pending entries are cleared by writeback end-of-packet beats. Accepted instructions pass through a one-entry registered output stage to the operands stage.

---
 rtl/issue_hazard_gate.sv | 105 ++++++++++
 tb/tb_issue_hazard_gate.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_hazard_gate.sv
// issue_hazard_gate: per-warp register scoreboard that sits between the
// instruction buffer and operand collection. It holds back any instruction
// that touches a register with an outstanding write, and it passes accepted
// instructions through a one-entry registered output stage.
module issue_hazard_gate #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS  = 64,
  parameter int WID_BITS  = 2,
  parameter int NR_BITS   = 6,
  parameter int DATAW     = 128,
  parameter int CTR_BITS  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WID_BITS-1:0] in_wid,
  input  logic                in_wb,
  input  logic [NR_BITS-1:0]  in_rd,
  input  logic [NR_BITS-1:0]  in_rs1,
  input  logic [NR_BITS-1:0]  in_rs2,
  input  logic [NR_BITS-1:0]  in_rs3,
  input  logic [DATAW-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WID_BITS-1:0] out_wid,
  output logic [DATAW-1:0]    out_data,
  input  logic                wb_valid,
  input  logic [WID_BITS-1:0] wb_wid,
  input  logic [NR_BITS-1:0]  wb_rd,
  input  logic                wb_eop,
  output logic [CTR_BITS-1:0] stall_count
);

  // One pending bit per (warp, register); a set bit means a write is in flight.
  logic [NUM_WARPS-1:0][NUM_REGS-1:0] pending_q;
  logic [NUM_WARPS-1:0][NUM_REGS-1:0] pending_d;

  logic [NUM_REGS-1:0] warp_pending;
  logic                hazard;
  logic                accept;
  logic                set_req;
  logic                clr_req;

  // Look up the issuing warp's scoreboard row and test every named register.
  // Only registered state is consulted, so a writeback in this same cycle
  // does not release the instruction until the next cycle.
  always_comb begin
    warp_pending = pending_q[in_wid];
    hazard = warp_pending[in_rs1] | warp_pending[in_rs2] | warp_pending[in_rs3] |
             (in_wb & warp_pending[in_rd]);
  end

  // Ready ignores in_valid so upstream can use it without a combinational loop.
  assign in_ready = ~hazard & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign set_req  = accept & in_wb & (in_rd != '0);
  assign clr_req  = wb_valid & wb_eop;

  // Next scoreboard: apply the writeback clear first so a same-entry set wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_req) begin
      pending_d[wb_wid][wb_rd] = 1'b0;
    end
    if (set_req) begin
      pending_d[in_wid][in_rd] = 1'b1;
    end
  end

  // Scoreboard register; register 0 can never be set, so it always reads clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Output stage: load on accept, drain when the operands stage takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_wid   <= '0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_wid   <= in_wid;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of cycles an offered instruction is blocked by a hazard;
  // output-full backpressure is deliberately excluded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (in_valid && hazard && (stall_count != {CTR_BITS{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_issue_hazard_gate.sv
// tb_issue_hazard_gate: directed bench for the issue hazard gate. A second
// instance with a 4-bit stall counter shares all inputs to cover saturation.
module tb_issue_hazard_gate;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_wid;
  logic         in_wb;
  logic [5:0]   in_rd;
  logic [5:0]   in_rs1;
  logic [5:0]   in_rs2;
  logic [5:0]   in_rs3;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_wid;
  logic [127:0] out_data;
  logic         wb_valid;
  logic [1:0]   wb_wid;
  logic [5:0]   wb_rd;
  logic         wb_eop;
  logic [15:0]  stall_count;

  logic         sat_in_ready;
  logic         sat_out_valid;
  logic [1:0]   sat_out_wid;
  logic [127:0] sat_out_data;
  logic [3:0]   sat_stall_count;

  int checks;
  int passed;

  issue_hazard_gate dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_wb(in_wb),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid), .out_data(out_data),
    .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_eop(wb_eop),
    .stall_count(stall_count)
  );

  issue_hazard_gate #(.CTR_BITS(4)) sat_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(sat_in_ready), .in_wid(in_wid), .in_wb(in_wb),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_data(in_data),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_wid(sat_out_wid),
    .out_data(sat_out_data),
    .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_eop(wb_eop),
    .stall_count(sat_stall_count)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction-buffer entry.
  task automatic applyStimulus(input logic v, input logic [1:0] wid, input logic wb,
                               input logic [5:0] rd, input logic [5:0] rs1,
                               input logic [5:0] rs2, input logic [5:0] rs3,
                               input logic [127:0] data);
    in_valid = v;
    in_wid   = wid;
    in_wb    = wb;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rs3   = rs3;
    in_data  = data;
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks = checks + 1;
    assert (observed === expected) passed = passed + 1;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  localparam logic [127:0] DA = 128'hA0A0_0000_0000_0000_0000_0000_0000_00A1;
  localparam logic [127:0] DB = 128'hB0B0_0000_0000_0000_0000_0000_0000_00B2;
  localparam logic [127:0] DC = 128'hC0C0_0000_0000_0000_0000_0000_0000_00C3;
  localparam logic [127:0] DD = 128'hD0D0_0000_0000_0000_0000_0000_0000_00D4;
  localparam logic [127:0] DE = 128'hE0E0_0000_0000_0000_0000_0000_0000_00E5;
  localparam logic [127:0] DF = 128'hF0F0_0000_0000_0000_0000_0000_0000_00F6;
  localparam logic [127:0] DG = 128'h1111_0000_0000_0000_0000_0000_0000_0017;
  localparam logic [127:0] DH = 128'h2222_0000_0000_0000_0000_0000_0000_0028;
  localparam logic [127:0] DI = 128'h3333_0000_0000_0000_0000_0000_0000_0039;
  localparam logic [127:0] DJ = 128'h4444_0000_0000_0000_0000_0000_0000_004A;

  // Linear directed sequence.
  initial begin
    checks    = 0;
    passed    = 0;
    reset     = 1'b1;
    out_ready = 1'b1;
    wb_valid  = 1'b0;
    wb_wid    = '0;
    wb_rd     = '0;
    wb_eop    = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, '0);
    #2;
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_out_wid", out_wid, 2'd0);
    checkOutput("reset_out_data", out_data, '0);
    checkOutput("reset_stall", stall_count, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // w0 writes x5.
    applyStimulus(1'b1, 2'd0, 1'b1, 6'd5, 6'd0, 6'd0, 6'd0, DA);
    checkOutput("first_in_ready", in_ready, 1'b1);
    tick();
    checkOutput("first_out_valid", out_valid, 1'b1);
    checkOutput("first_out_data", out_data, DA);
    checkOutput("first_out_wid", out_wid, 2'd0);

    // RAW: w0 reads x5, stalls for three edges while the output drains.
    applyStimulus(1'b1, 2'd0, 1'b0, 6'd0, 6'd5, 6'd0, 6'd0, DB);
    checkOutput("raw_in_ready", in_ready, 1'b0);
    tick();
    checkOutput("raw_drain", out_valid, 1'b0);
    checkOutput("raw_stall1", stall_count, 16'd1);
    tick();
    tick();
    checkOutput("raw_stall3", stall_count, 16'd3);

    // Isolation: w1 reading x5 is unaffected by w0's pending write.
    applyStimulus(1'b1, 2'd1, 1'b0, 6'd0, 6'd5, 6'd0, 6'd0, DC);
    checkOutput("iso_in_ready", in_ready, 1'b1);
    tick();
    checkOutput("iso_out_wid", out_wid, 2'd1);
    checkOutput("iso_out_data", out_data, DC);
    checkOutput("iso_stall", stall_count, 16'd3);

    // Non-eop writeback beat leaves x5 pending.
    applyStimulus(1'b1, 2'd0, 1'b0, 6'd0, 6'd5, 6'd0, 6'd0, DB);
    wb_valid = 1'b1; wb_wid = 2'd0; wb_rd = 6'd5; wb_eop = 1'b0;
    tick();
    checkOutput("noeop_in_ready", in_ready, 1'b0);
    checkOutput("noeop_stall", stall_count, 16'd4);

    // Eop beat: no same-cycle bypass, released on the following cycle.
    wb_eop = 1'b1;
    #1;
    checkOutput("eop_no_bypass", in_ready, 1'b0);
    tick();
    wb_valid = 1'b0; wb_eop = 1'b0;
    #1;
    checkOutput("eop_released", in_ready, 1'b1);
    checkOutput("eop_stall", stall_count, 16'd5);
    tick();
    checkOutput("raw_out_data", out_data, DB);
    checkOutput("raw_out_valid", out_valid, 1'b1);
    checkOutput("raw_stall_frozen", stall_count, 16'd5);
    applyStimulus(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, '0);
    tick();
    checkOutput("idle_out_valid", out_valid, 1'b0);

    // Write to x0 never creates a hazard.
    applyStimulus(1'b1, 2'd3, 1'b1, 6'd0, 6'd0, 6'd0, 6'd0, DD);
    tick();
    applyStimulus(1'b1, 2'd3, 1'b1, 6'd0, 6'd0, 6'd0, 6'd0, DE);
    checkOutput("x0_in_ready", in_ready, 1'b1);
    tick();
    checkOutput("x0_out_data", out_data, DE);

    // WAW on w2 x7.
    applyStimulus(1'b1, 2'd2, 1'b1, 6'd7, 6'd0, 6'd0, 6'd0, DF);
    tick();
    applyStimulus(1'b1, 2'd2, 1'b1, 6'd7, 6'd0, 6'd0, 6'd0, DG);
    checkOutput("waw_in_ready", in_ready, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0, 6'd7, 6'd1, 6'd2, 6'd3, DG);
    checkOutput("waw_nowb_in_ready", in_ready, 1'b1);
    tick();
    checkOutput("waw_out_data", out_data, DG);
    checkOutput("waw_out_wid", out_wid, 2'd2);
    checkOutput("waw_stall", stall_count, 16'd5);

    // Backpressure: output held, input blocked, not counted as a stall.
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'd3, 1'b0, 6'd0, 6'd1, 6'd0, 6'd0, DH);
    checkOutput("bp_in_ready", in_ready, 1'b0);
    tick();
    tick();
    checkOutput("bp_out_data", out_data, DG);
    checkOutput("bp_out_valid", out_valid, 1'b1);
    checkOutput("bp_stall", stall_count, 16'd5);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", in_ready, 1'b1);
    tick();
    checkOutput("bp_new_data", out_data, DH);
    checkOutput("bp_no_bubble", out_valid, 1'b1);
    applyStimulus(1'b1, 2'd3, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, DI);
    tick();
    checkOutput("tput_out_data", out_data, DI);
    checkOutput("tput_out_valid", out_valid, 1'b1);

    // Saturation: w2 x7 is still pending; stall 20 more cycles.
    applyStimulus(1'b1, 2'd2, 1'b0, 6'd0, 6'd7, 6'd0, 6'd0, DJ);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("sat_wide_stall", stall_count, 16'd25);
    checkOutput("sat_narrow_stall", sat_stall_count, 4'd15);

    // Async reset mid-cycle while holding an output instruction.
    applyStimulus(1'b1, 2'd1, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, DJ);
    tick();
    applyStimulus(1'b0, 2'd2, 1'b0, 6'd0, 6'd7, 6'd0, 6'd0, '0);
    out_ready = 1'b0;
    checkOutput("pre_reset_out_valid", out_valid, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("async_out_valid", out_valid, 1'b0);
    checkOutput("async_out_data", out_data, '0);
    checkOutput("async_stall", stall_count, 16'd0);
    checkOutput("async_sat_stall", sat_stall_count, 4'd0);
    checkOutput("async_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b1, 2'd2, 1'b0, 6'd0, 6'd7, 6'd0, 6'd0, DA);
    checkOutput("post_reset_pending_clear", in_ready, 1'b1);
    tick();
    checkOutput("post_reset_out_data", out_data, DA);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
